mac_result_drain: RTL and testbench
===================================

// Module: mac_result_drain
// PURPOSE
//  Consumer end of the MAC-array result interface: captures per-lane accumulator results
//  (acc_out_k qualified by valid_out[k]), assembles complete N_MACS-lane frames, buffers
//  them in a frame FIFO and serialises them as a valid/ready lane stream. Requests an
//  array clear after each captured frame. Sits between mac_array and downstream writeback.
// PARAMETERS
//  ACC_W   16  accumulator / output data width
//  N_MACS  4   lanes per frame (fixed 4: one acc_in_k port per lane)
//  DEPTH   4   frame FIFO depth in frames; power of 2, >= 2
// PORTS
//  clk        in   1               clock, all logic on rising edge
//  rst        in   1               synchronous, active-low reset
//  acc_in_0   in   ACC_W (signed)  lane 0 accumulator result
//  acc_in_1   in   ACC_W (signed)  lane 1 accumulator result
//  acc_in_2   in   ACC_W (signed)  lane 2 accumulator result
//  acc_in_3   in   ACC_W (signed)  lane 3 accumulator result
//  valid_in   in   N_MACS          per-lane result-valid; bit k qualifies acc_in_k
//  flush      in   1               close current partial frame; missing lanes read as 0
//  out_data   out  ACC_W (signed)  stream data (one lane per beat)
//  out_lane   out  2               lane index of current beat
//  out_last   out  1               high on lane N_MACS-1 beat of a frame
//  out_valid  out  1               stream beat available
//  out_ready  in   1               downstream accepts beat
//  clear_req  out  1               one-cycle pulse: clear array accumulators
//  level      out  $clog2(DEPTH)+1 frames held in FIFO
//  overflow   out  1               sticky: frame dropped because FIFO full
//  dup_err    out  1               sticky: lane valid while that lane already held
//  busy       out  1               partial frame held, or FIFO non-empty
// BEHAVIOUR
//  Reset (rst=0 at edge): lane_full=0, lane regs=0, FIFO empty, rd/wr ptrs=0, lane_idx=0,
//   all outputs 0; overrides every other event that cycle.
//  Capture: at edge where valid_in[k]=1 and lane_full[k]=0: lane_reg[k]<=acc_in_k, lane_full[k]<=1.
//   valid_in[k]=1 with lane_full[k]=1 (and frame not completing): input ignored, dup_err<=1.
//  Frame complete when (lane_full|valid_in)==all-ones, or flush=1 with any lane held/valid.
//   Same edge: frame (lane_reg or incoming acc_in_k; unheld lanes=0) written to FIFO,
//   lane_full<=0. flush with nothing held/valid: no-op, no clear_req.
//  clear_req=1 exactly the cycle after a frame completes (written or dropped).
//  Push when full: frame dropped, overflow<=1, unless a pop (last beat accepted) occurs the
//   same cycle, in which case push succeeds and level is unchanged.
//  Stream: out_valid = FIFO non-empty; out_data = head[lane_idx]; out_lane = lane_idx;
//   out_last = (lane_idx==N_MACS-1). Beat fires on out_valid&out_ready: lane_idx++;
//   on last beat lane_idx<=0 and head popped. out_data/out_lane stable while valid & !ready.
//  Latency: frame completing at edge N -> out_valid high in cycle N+1 if FIFO was empty.
//  Pointers wrap modulo DEPTH; level = wr-rd with extra MSB; full when level==DEPTH.
//  Sticky flags clear only on reset. Arithmetic: none; values passed bit-exact.
//  busy = |lane_full | (level!=0).
// TESTING
//  valid_in=4'b1111, acc=1,-2,3,-4, ready=1 -> beats 1,-2,3,-4 lanes 0..3, last on 4th, clear_req 1 cyc.
//  Staggered valid_in 0001,0010,0100,1000 on 4 cycles -> one frame pushed on 4th edge, clear_req next cycle.
//  valid_in=0011 then flush -> frame {a0,a1,0,0} emitted; flush on empty -> no beat, no clear_req.
//  ready=0, 5 full frames with DEPTH=4 -> level=4, overflow=1, first 4 frames intact in order.
//  Full FIFO, push coincident with last-beat pop -> no overflow, level stays 4.
//  valid_in=0001 twice -> dup_err=1, first value kept; rst=0 mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mac_result_drain.sv
// Result drain for the MAC array: gathers per-lane accumulator results into frames,
// queues whole frames in a small FIFO and replays them one lane per beat downstream.
module mac_result_drain #(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [ACC_W-1:0]    acc_in_0,
  input  logic signed [ACC_W-1:0]    acc_in_1,
  input  logic signed [ACC_W-1:0]    acc_in_2,
  input  logic signed [ACC_W-1:0]    acc_in_3,
  input  logic [N_MACS-1:0]          valid_in,
  input  logic                       flush,
  output logic signed [ACC_W-1:0]    out_data,
  output logic [1:0]                 out_lane,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       clear_req,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       dup_err,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  acc_t              acc_in [N_MACS];
  acc_t              frame  [N_MACS];
  acc_t              lane_reg_q [N_MACS];
  acc_t              lane_reg_d [N_MACS];
  acc_t              mem_q [DEPTH][N_MACS];
  acc_t              mem_d [DEPTH][N_MACS];
  logic [N_MACS-1:0] lane_full_q, lane_full_d;
  logic [N_MACS-1:0] held;
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_w;
  logic [1:0]        lane_idx_q, lane_idx_d;
  logic              clear_req_q, clear_req_d;
  logic              overflow_q, overflow_d;
  logic              dup_err_q, dup_err_d;
  logic              complete, fifo_full, fire, pop;

  assign acc_in[0] = acc_in_0;
  assign acc_in[1] = acc_in_1;
  assign acc_in[2] = acc_in_2;
  assign acc_in[3] = acc_in_3;

  always_comb begin
    held        = lane_full_q | valid_in;
    complete    = (&held) | (flush & (|held));
    level_w     = wr_ptr_q - rd_ptr_q;
    fifo_full   = (level_w == LW'(DEPTH));
    fire        = (level_w != '0) & out_ready;
    pop         = fire & (lane_idx_q == 2'(N_MACS - 1));

    lane_full_d = lane_full_q;
    lane_reg_d  = lane_reg_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lane_idx_d  = lane_idx_q;
    clear_req_d = complete;
    overflow_d  = overflow_q;
    dup_err_d   = dup_err_q;

    // Held lanes win over a same-cycle duplicate; lanes never seen read as zero.
    for (int k = 0; k < N_MACS; k++) begin
      if (lane_full_q[k])    frame[k] = lane_reg_q[k];
      else if (valid_in[k])  frame[k] = acc_in[k];
      else                   frame[k] = '0;
    end

    if (fire) lane_idx_d = pop ? 2'd0 : lane_idx_q + 2'd1;
    if (pop)  rd_ptr_d   = rd_ptr_q + LW'(1);

    if (complete) begin
      lane_full_d = '0;
      // A full FIFO still accepts the frame when its head leaves this same cycle.
      if (!fifo_full || pop) begin
        mem_d[wr_ptr_q[AW-1:0]] = frame;
        wr_ptr_d                = wr_ptr_q + LW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      for (int k = 0; k < N_MACS; k++) begin
        if (valid_in[k]) begin
          if (lane_full_q[k]) begin
            dup_err_d = 1'b1;
          end else begin
            lane_full_d[k] = 1'b1;
            lane_reg_d[k]  = acc_in[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_full_q <= '0;
      for (int k = 0; k < N_MACS; k++) lane_reg_q[k] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lane_idx_q  <= '0;
      clear_req_q <= 1'b0;
      overflow_q  <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      lane_full_q <= lane_full_d;
      lane_reg_q  <= lane_reg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lane_idx_q  <= lane_idx_d;
      clear_req_q <= clear_req_d;
      overflow_q  <= overflow_d;
      dup_err_q   <= dup_err_d;
    end
  end

  // Frame storage carries data only; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = (level_w != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q[AW-1:0]][lane_idx_q] : '0;
  assign out_lane  = lane_idx_q;
  assign out_last  = (lane_idx_q == 2'(N_MACS - 1));
  assign clear_req = clear_req_q;
  assign level     = level_w;
  assign overflow  = overflow_q;
  assign dup_err   = dup_err_q;
  assign busy      = (|lane_full_q) | (level_w != '0);

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: frame-queue reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_mac_result_drain;

  typedef logic signed [15:0] s16;
  typedef s16 frame_t [4];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  s16          acc0 = '0, acc1 = '0, acc2 = '0, acc3 = '0;
  logic [3:0]  valid_in = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  s16          out_data;
  logic [1:0]  out_lane;
  logic        out_last, out_valid, clear_req, overflow, dup_err, busy;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  // reference model state (post-edge)
  bit     m_lf [4];
  s16     m_lr [4];
  frame_t m_q [$];
  int     m_idx = 0;
  bit     m_clr = 0, m_ovf = 0, m_dup = 0;

  always #5 clk = ~clk;

  mac_result_drain #(.ACC_W(16), .N_MACS(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .acc_in_0(acc0), .acc_in_1(acc1), .acc_in_2(acc2), .acc_in_3(acc3),
    .valid_in(valid_in), .flush(flush),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .clear_req(clear_req),
    .level(level), .overflow(overflow), .dup_err(dup_err), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] v, input s16 a [4], input bit f,
                            input bit r, input bit rs);
    bit any, all, complete, full_before, pop;
    frame_t fr;
    if (!rs) begin
      for (int k = 0; k < 4; k++) begin m_lf[k] = 0; m_lr[k] = 0; end
      m_q.delete(); m_idx = 0; m_clr = 0; m_ovf = 0; m_dup = 0;
      return;
    end
    any = 0; all = 1;
    for (int k = 0; k < 4; k++) begin
      any |= (m_lf[k] || v[k]);
      all &= (m_lf[k] || v[k]);
      fr[k] = m_lf[k] ? m_lr[k] : (v[k] ? a[k] : s16'(0));
    end
    complete    = all || (f && any);
    full_before = (m_q.size() == 4);
    pop = 0;
    if (m_q.size() > 0 && r) begin
      if (m_idx == 3) begin pop = 1; m_idx = 0; void'(m_q.pop_front()); end
      else m_idx++;
    end
    if (complete) begin
      if (!full_before || pop) m_q.push_back(fr);
      else m_ovf = 1;
      for (int k = 0; k < 4; k++) m_lf[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (v[k]) begin
          if (m_lf[k]) m_dup = 1;
          else begin m_lf[k] = 1; m_lr[k] = a[k]; end
        end
    end
    m_clr = complete;
  endtask

  task automatic step(input logic [3:0] v, input int a0, input int a1, input int a2,
                      input int a3, input bit f, input bit r, input bit rs);
    s16 a [4];
    @(negedge clk);
    a[0] = s16'(a0); a[1] = s16'(a1); a[2] = s16'(a2); a[3] = s16'(a3);
    valid_in = v; acc0 = a[0]; acc1 = a[1]; acc2 = a[2]; acc3 = a[3];
    flush = f; out_ready = r; rst = rs;
    model_step(v, a, f, r, rs);
  endtask

  task automatic idle(input bit r);
    step(4'b0000, 0, 0, 0, 0, 0, r, 1);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  // Compare process: after every active edge the outputs must match the model.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (run) begin
        bit ev, anyl;
        ev = (m_q.size() != 0);
        anyl = 0;
        for (int k = 0; k < 4; k++) anyl |= m_lf[k];
        chk("out_valid", int'(out_valid), int'(ev));
        chk("out_data", int'(out_data), ev ? int'(m_q[0][m_idx]) : 0);
        chk("out_lane", int'(out_lane), m_idx);
        chk("out_last", int'(out_last), int'(m_idx == 3));
        chk("clear_req", int'(clear_req), int'(m_clr));
        chk("level", int'(level), m_q.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("dup_err", int'(dup_err), int'(m_dup));
        chk("busy", int'(busy), int'(anyl || ev));
      end
    end
  end

  initial begin
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    run = 1;
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);

    // full frame in one cycle
    step(4'b1111, 1, -2, 3, -4, 0, 1, 1);
    settle();
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_clear", int'(clear_req), 1);
    chk("t1_d0", int'(out_data), 1);
    idle(1); settle();
    chk("t1_d1", int'(out_data), -2);
    chk("t1_clear_off", int'(clear_req), 0);
    idle(1); settle();
    chk("t1_d2", int'(out_data), 3);
    idle(1); settle();
    chk("t1_d3", int'(out_data), -4);
    chk("t1_last", int'(out_last), 1);
    idle(1); settle();
    chk("t1_empty", int'(out_valid), 0);

    // staggered lanes
    step(4'b0001, 5, 0, 0, 0, 0, 0, 1);
    step(4'b0010, 0, 6, 0, 0, 0, 0, 1);
    step(4'b0100, 0, 0, 7, 0, 0, 0, 1);
    settle();
    chk("t2_partial_level", int'(level), 0);
    chk("t2_partial_busy", int'(busy), 1);
    step(4'b1000, 0, 0, 0, 8, 0, 0, 1);
    settle();
    chk("t2_level", int'(level), 1);
    chk("t2_clear", int'(clear_req), 1);
    chk("t2_d0", int'(out_data), 5);
    repeat (4) idle(1);
    settle();
    chk("t2_drained", int'(level), 0);

    // partial frame closed by flush, then flush on empty
    step(4'b0011, 9, 10, 0, 0, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 0, 1, 0, 1);
    settle();
    chk("t3_level", int'(level), 1);
    chk("t3_d0", int'(out_data), 9);
    idle(1); idle(1); settle();
    chk("t3_lane2", int'(out_lane), 2);
    chk("t3_d2_zero", int'(out_data), 0);
    idle(1); idle(1);
    step(4'b0000, 0, 0, 0, 0, 1, 1, 1);
    settle();
    chk("t3_noclear", int'(clear_req), 0);
    chk("t3_nobeat", int'(out_valid), 0);

    // fill FIFO, push coincident with pop, then overflow
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    for (int f = 0; f < 4; f++) step(4'b1111, f*10, f*10+1, f*10+2, f*10+3, 0, 0, 1);
    settle();
    chk("t5_level_full", int'(level), 4);
    repeat (3) idle(1);
    step(4'b1111, 40, 41, 42, 43, 0, 1, 1);
    settle();
    chk("t5_level_kept", int'(level), 4);
    chk("t5_no_ovf", int'(overflow), 0);
    chk("t5_head", int'(out_data), 10);
    step(4'b1111, 50, 51, 52, 53, 0, 0, 1);
    settle();
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_level", int'(level), 4);
    repeat (16) idle(1);

    // duplicate lane, then mid-stream reset
    step(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    step(4'b0001, 7, 0, 0, 0, 0, 0, 1);
    step(4'b0001, 8, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t6_dup", int'(dup_err), 1);
    step(4'b1110, 0, 11, 12, 13, 0, 0, 1);
    settle();
    chk("t6_kept_first", int'(out_data), 7);
    step(4'b0000, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_dup", int'(dup_err), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_data", int'(out_data), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      step(v, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6),
           !(i == 1500 || i == 2500));
    end
    @(posedge clk); #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
